// File: rtl/craps_pkg.sv
// Shared types and constants for the craps game controller.
package craps_pkg;

    typedef enum logic [1:0] {
        COME_OUT = 2'd0,
        POINT    = 2'd1,
        WIN      = 2'd2,
        LOSE     = 2'd3
    } state_t;

    localparam int SUM_WIDTH = 4;
    localparam logic [SUM_WIDTH-1:0] SUM_MIN = 4'd2;
    localparam logic [SUM_WIDTH-1:0] SUM_MAX = 4'd12;

    function automatic logic sum_in_range(input logic [SUM_WIDTH-1:0] sum);
        return (sum >= SUM_MIN) && (sum <= SUM_MAX);
    endfunction

endpackage

// File: rtl/point_compare.sv
// Holds the established point and compares each roll against it.
import craps_pkg::*;

module point_compare (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clock_en,
    input  logic                 load,
    input  logic                 clear,
    input  logic [SUM_WIDTH-1:0] num,
    output logic [SUM_WIDTH-1:0] point,
    output logic                 match
);

    logic [SUM_WIDTH-1:0] point_r;

    // Point register: clear wins over load so a restart never keeps a stale point.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            point_r <= 4'd0;
        end else if (clock_en) begin
            if (clear) begin
                point_r <= 4'd0;
            end else if (load) begin
                point_r <= num;
            end
        end
    end

    assign point = point_r;
    assign match = (num == point_r);

endmodule

// File: rtl/game_controller.sv
// Craps pass-line game FSM. Optional accepted-roll counter enabled by macro ROLL_COUNT_EN.
import craps_pkg::*;

module game_controller #(
    parameter int CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clock_en,
    input  logic                 roll_valid,
    input  logic [SUM_WIDTH-1:0] num,
    input  logic                 D7,
    input  logic                 D711,
    input  logic                 D2312,
    input  logic                 new_game,
    output logic                 win,
    output logic                 lose,
    output logic [SUM_WIDTH-1:0] point,
    output logic                 point_valid,
    output logic [1:0]           state
`ifdef ROLL_COUNT_EN
    ,
    output logic [CNT_W-1:0]     roll_count
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_t state_r;
    logic   win_r;
    logic   lose_r;
    logic   point_valid_r;
    logic   accept_s;
    logic   range_ok_s;
    logic   load_point_s;
    logic   clear_s;
    logic   match_s;

    assign accept_s     = clock_en && roll_valid && !new_game &&
                          ((state_r == COME_OUT) || (state_r == POINT));
    assign range_ok_s   = sum_in_range(num);
    assign clear_s      = clock_en && new_game;
    assign load_point_s = accept_s && (state_r == COME_OUT) && range_ok_s && !D711 && !D2312;

    point_compare u_point_compare (
        .clock    (clock),
        .reset_n  (reset_n),
        .clock_en (clock_en),
        .load     (load_point_s),
        .clear    (clear_s),
        .num      (num),
        .point    (point),
        .match    (match_s)
    );

    // Game FSM; flag outputs are registered alongside the state they describe.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r       <= COME_OUT;
            win_r         <= 1'b0;
            lose_r        <= 1'b0;
            point_valid_r <= 1'b0;
        end else if (clock_en) begin
            if (new_game) begin
                state_r       <= COME_OUT;
                win_r         <= 1'b0;
                lose_r        <= 1'b0;
                point_valid_r <= 1'b0;
            end else if (roll_valid) begin
                case (state_r)
                    COME_OUT: begin
                        if (range_ok_s) begin
                            if (D711) begin
                                state_r <= WIN;
                                win_r   <= 1'b1;
                            end else if (D2312) begin
                                state_r <= LOSE;
                                lose_r  <= 1'b1;
                            end else begin
                                state_r       <= POINT;
                                point_valid_r <= 1'b1;
                            end
                        end
                    end
                    POINT: begin
                        // Matching the point outranks a seven.
                        if (match_s) begin
                            state_r       <= WIN;
                            win_r         <= 1'b1;
                            point_valid_r <= 1'b0;
                        end else if (D7) begin
                            state_r       <= LOSE;
                            lose_r        <= 1'b1;
                            point_valid_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= state_r;
                    end
                endcase
            end
        end
    end

    assign win         = win_r;
    assign lose        = lose_r;
    assign point_valid = point_valid_r;
    assign state       = state_r;

`ifdef ROLL_COUNT_EN
    logic [CNT_W-1:0] roll_count_r;
    logic             count_step_s;

    // Out-of-range come-out rolls are dropped, so they must not be counted either.
    assign count_step_s = accept_s && ((state_r == POINT) || range_ok_s);

    // Saturating accepted-roll counter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            roll_count_r <= {CNT_W{1'b0}};
        end else if (clock_en) begin
            if (new_game) begin
                roll_count_r <= {CNT_W{1'b0}};
            end else if (count_step_s && (roll_count_r != {CNT_W{1'b1}})) begin
                roll_count_r <= roll_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign roll_count = roll_count_r;
`endif

endmodule
